seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (range 2..16).
REQ-002 SHALL have parameter CLK_DIV, default 50000, iCLK cycles per digit slot (minimum 2).
REQ-003 SHALL have port iCLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port iRST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port iDATA  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i; digit 0 is least significant.
REQ-006 SHALL have port iLOAD  input  1  one-cycle strobe that captures iDATA.
REQ-007 SHALL have port iBLANK_MASK  input  NUM_DIGITS  bit i high forces digit i dark; sampled live, no latching.
REQ-008 SHALL have port oSEG  output  7  segment drive, active-low, bit order g,f,e,d,c,b,a (bit 6..0).
REQ-009 SHALL have port oDIG_SEL  output  NUM_DIGITS  digit enables, active-low, one-hot-low while scanning.
REQ-010 SHALL have port oPEND  output  1  high while captured data awaits commit.
REQ-011 SHALL have port oACK  output  1  one-cycle pulse when captured data is committed to display.

Function
REQ-012 Prescaler SHALL count 0..CLK_DIV-1 and wrap; "tick" = cycle in which count equals CLK_DIV-1.
REQ-013 On each tick, digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-014 "Frame boundary" SHALL be a tick with index equal to NUM_DIGITS-1.
REQ-015 oSEG and oDIG_SEL SHALL be registered, updating on the edge ending a tick cycle to show the new index; latency tick -> output = 1 cycle.
REQ-016 Glyphs (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 A dark digit SHALL output oSEG=1111111 while its oDIG_SEL bit is still driven low.
REQ-018 iLOAD SHALL copy iDATA into staging register and set oPEND the next cycle; a further iLOAD while pending SHALL overwrite staging (last wins).
REQ-019 At frame boundary with oPEND high, staging SHALL copy to display register, oPEND clear, oACK pulse 1 cycle, all on the same edge; no torn frames.
REQ-020 iLOAD coincident with a pending frame boundary: old staging commits, new iDATA captured, oPEND stays high, oACK pulses.
REQ-021 Display register SHALL change only at frame boundaries.

Reset
REQ-022 iRST_N low SHALL immediately force: prescaler 0, index 0, staging and display 0, oSEG=1111111, oDIG_SEL all ones, oPEND=0, oACK=0.
REQ-023 Reset mid-frame or mid-pending SHALL discard pending data; no oACK after release.
REQ-024 After release, outputs stay dark until first tick (CLK_DIV cycles), then show digit 1.

Configuration
REQ-025 Macro SEG7_LZB_EN defined: digit i>0 SHALL be dark when display nibbles i..NUM_DIGITS-1 are all zero; digit 0 never blanked by this rule.
REQ-026 SEG7_LZB_EN undefined: no leading-zero blanking; only iBLANK_MASK darkens digits.

Verification (NUM_DIGITS=4, CLK_DIV=4)
REQ-027 Reset then iDATA=16'h1234, iLOAD -> oPEND=1; at first frame boundary oACK pulse; subsequent scan digit0 oSEG=0011001 (4), digit3 oSEG=1111001 (1), oDIG_SEL 1110,1101,1011,0111 each 4 cycles.
REQ-028 iDATA=16'h00A0 committed, SEG7_LZB_EN defined -> digits 3,2 oSEG=1111111, digit1=0001000, digit0=1000000; undefined -> digits 3,2 show 1000000.
REQ-029 Two iLOADs (16'hAAAA then 16'h5555) within one frame -> single oACK, display shows 5555 only.
REQ-030 iLOAD on frame-boundary cycle with prior pending data -> oACK pulse, oPEND remains 1, second data commits next boundary.
REQ-031 iBLANK_MASK=4'b0100 -> digit 2 oSEG=1111111 on next visit of digit 2; clearing restores glyph.
REQ-032 iRST_N pulsed low mid-frame with oPEND=1 -> outputs dark immediately, oPEND=0, no oACK, scan restarts at digit 1 after 4 cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with double-buffered display data.
// Data captured by iLOAD is staged and only committed to the display at a
// frame boundary (after the last digit slot), so a frame never mixes old and
// new data. Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 50000
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic                    iLOAD,
    input  logic [NUM_DIGITS-1:0]   iBLANK_MASK,
    output logic [6:0]              oSEG,
    output logic [NUM_DIGITS-1:0]   oDIG_SEL,
    output logic                    oPEND,
    output logic                    oACK
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]        prescaleQ;
    logic [IDX_W-1:0]        digitIdxQ;
    logic [IDX_W-1:0]        nextIdx;
    logic [4*NUM_DIGITS-1:0] stageQ;
    logic [4*NUM_DIGITS-1:0] dispQ;
    logic [4*NUM_DIGITS-1:0] dispNext;
    logic [NUM_DIGITS-1:0]   lzbDark;
    logic                    allZero;
    logic                    tick;
    logic                    frameEnd;
    logic                    commit;
    logic [3:0]              nibble;
    logic                    dark;

    function automatic logic [6:0] hexGlyph(input logic [3:0] n);
        case (n)
            4'h0:    hexGlyph = 7'b1000000;
            4'h1:    hexGlyph = 7'b1111001;
            4'h2:    hexGlyph = 7'b0100100;
            4'h3:    hexGlyph = 7'b0110000;
            4'h4:    hexGlyph = 7'b0011001;
            4'h5:    hexGlyph = 7'b0010010;
            4'h6:    hexGlyph = 7'b0000010;
            4'h7:    hexGlyph = 7'b1111000;
            4'h8:    hexGlyph = 7'b0000000;
            4'h9:    hexGlyph = 7'b0011000;
            4'hA:    hexGlyph = 7'b0001000;
            4'hB:    hexGlyph = 7'b0000011;
            4'hC:    hexGlyph = 7'b1000110;
            4'hD:    hexGlyph = 7'b0100001;
            4'hE:    hexGlyph = 7'b0000110;
            default: hexGlyph = 7'b0001110;
        endcase
    endfunction

    // Slot timing, frame boundary and the display value the next slot will show
    always_comb begin
        tick     = (prescaleQ == CNT_W'(CLK_DIV - 1));
        nextIdx  = (digitIdxQ == IDX_W'(NUM_DIGITS - 1)) ? '0 : digitIdxQ + IDX_W'(1);
        frameEnd = tick && (digitIdxQ == IDX_W'(NUM_DIGITS - 1));
        commit   = frameEnd && oPEND;
        // Glyphs use the post-commit value so digit 0 of a new frame is already new data
        dispNext = commit ? stageQ : dispQ;
        nibble   = dispNext[4*nextIdx +: 4];
    end

    // Leading-zero blanking: digit i>0 dark when it and every higher nibble is zero
    always_comb begin
        lzbDark = '0;
        allZero = 1'b1;
`ifdef SEG7_LZB_EN
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            allZero    = allZero && (dispNext[4*i +: 4] == 4'h0);
            lzbDark[i] = (i != 0) && allZero;
        end
`endif
        dark = iBLANK_MASK[nextIdx] || lzbDark[nextIdx];
    end

    // Prescaler and digit index
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            prescaleQ <= '0;
            digitIdxQ <= '0;
        end else begin
            prescaleQ <= tick ? '0 : prescaleQ + CNT_W'(1);
            if (tick) begin
                digitIdxQ <= nextIdx;
            end
        end
    end

    // Staging capture, frame-boundary commit and handshake flags
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stageQ <= '0;
            dispQ  <= '0;
            oPEND  <= 1'b0;
            oACK   <= 1'b0;
        end else begin
            oACK <= commit;
            if (commit) begin
                dispQ <= stageQ;
            end
            if (iLOAD) begin
                stageQ <= iDATA;
            end
            // A load on the commit edge re-arms pending for the newly captured data
            oPEND <= iLOAD || (oPEND && !commit);
        end
    end

    // Registered segment and digit-select drive, refreshed at every slot change
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oSEG     <= 7'b1111111;
            oDIG_SEL <= '1;
        end else if (tick) begin
            oSEG     <= dark ? 7'b1111111 : hexGlyph(nibble);
            oDIG_SEL <= ~(NUM_DIGITS'(1) << nextIdx);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, CLK_DIV=4).
// A cycle-count based reference model is compared against the DUT every cycle,
// with directed scenarios adding literal expectations. Define SEG7_LZB_EN to
// test the leading-zero blanking build.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int CD = 4;
    localparam logic [6:0] DARK = 7'b1111111;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic [15:0]   iDATA = '0;
    logic          iLOAD = 1'b0;
    logic [ND-1:0] iBLANK_MASK = '0;
    logic [6:0]    oSEG;
    logic [ND-1:0] oDIG_SEL;
    logic          oPEND;
    logic          oACK;

    int errors = 0;
    int checks = 0;
    int ackTotal = 0;
    bit checkEn = 1'b0;

    seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iLOAD(iLOAD),
        .iBLANK_MASK(iBLANK_MASK), .oSEG(oSEG), .oDIG_SEL(oDIG_SEL),
        .oPEND(oPEND), .oACK(oACK)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since reset, number of slot changes, and the
    // staged/shown data words.
    int          t;
    int          ticks;
    logic [15:0] mDisp;
    logic [15:0] mStage;
    logic        mPend;
    logic        mAck;
    logic [6:0]  mSeg;
    logic [3:0]  mSel;

    function automatic bit digitDark(input int n, input logic [15:0] disp, input logic [3:0] mask);
        bit d;
        d = mask[n];
`ifdef SEG7_LZB_EN
        if (n > 0 && (disp >> (4 * n)) == 16'h0) d = 1'b1;
`endif
        return d;
    endfunction

    always @(posedge iCLK or negedge iRST_N) begin
        logic [15:0] nDisp;
        logic [15:0] nStage;
        logic        nPend;
        logic        nAck;
        logic [3:0]  nSel;
        logic [3:0]  nib;
        int          cur;
        int          nxt;
        bit          isTick;
        if (!iRST_N) begin
            t <= 0; ticks <= 0; mDisp <= '0; mStage <= '0; mPend <= 1'b0;
            mAck <= 1'b0; mSeg <= DARK; mSel <= '1;
        end else begin
            nDisp = mDisp; nStage = mStage; nPend = mPend; nAck = 1'b0;
            isTick = (t % CD) == CD - 1;
            cur = ticks % ND;
            if (isTick && cur == ND - 1 && mPend) begin
                nDisp = mStage; nAck = 1'b1; nPend = 1'b0;
            end
            if (iLOAD) begin
                nStage = iDATA; nPend = 1'b1;
            end
            if (isTick) begin
                nxt = (ticks + 1) % ND;
                nSel = '1;
                nSel[nxt] = 1'b0;
                nib = nDisp[4*nxt +: 4];
                mSel <= nSel;
                mSeg <= digitDark(nxt, nDisp, iBLANK_MASK) ? DARK : GLYPH[nib];
                ticks <= ticks + 1;
            end
            mDisp <= nDisp; mStage <= nStage; mPend <= nPend; mAck <= nAck;
            t <= t + 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge iCLK) begin
        #1;
        if (checkEn) begin
            check("seg", 16'(oSEG), 16'(mSeg));
            check("dig_sel", 16'(oDIG_SEL), 16'(mSel));
            check("pend", 16'(oPEND), 16'(mPend));
            check("ack", 16'(oACK), 16'(mAck));
        end
        if (oACK === 1'b1) ackTotal++;
    end

    task automatic waitSel(input logic [3:0] s, input int budget);
        int n = 0;
        do begin
            @(posedge iCLK); #1; n++;
        end while (oDIG_SEL !== s && n < budget);
        if (oDIG_SEL !== s) check("wait_dig_sel_timeout", 16'(oDIG_SEL), 16'(s));
    endtask

    task automatic waitAck(input int budget);
        int n = 0;
        do begin
            @(posedge iCLK); #1; n++;
        end while (oACK !== 1'b1 && n < budget);
        if (oACK !== 1'b1) check("wait_ack_timeout", 16'(oACK), 16'd1);
    endtask

    task automatic load(input logic [15:0] d);
        @(negedge iCLK); iDATA = d; iLOAD = 1'b1;
        @(negedge iCLK); iLOAD = 1'b0;
    endtask

    initial begin
        int ackSnap;
        logic [6:0] lzbExp;

        // Reset
        #1 checkEn = 1'b1;
        repeat (3) @(negedge iCLK);
        check("reset_seg", 16'(oSEG), 16'h7F);
        check("reset_sel", 16'(oDIG_SEL), 16'hF);
        check("reset_pend", 16'(oPEND), 16'h0);
        iRST_N = 1'b1;

        // Basic load, commit and scan of 1234
        load(16'h1234);
        check("pend_after_load", 16'(oPEND), 16'h1);
        waitAck(40);
        check("frame0_sel", 16'(oDIG_SEL), 16'hE);
        check("frame0_seg_digit0", 16'(oSEG), 16'(7'b0011001));
        waitSel(4'b0111, 20);
        check("seg_digit3", 16'(oSEG), 16'(7'b1111001));

        // Leading zeros
        load(16'h00A0);
        waitAck(40);
        check("lz_digit0", 16'(oSEG), 16'(7'b1000000));
        waitSel(4'b1101, 20);
        check("lz_digit1", 16'(oSEG), 16'(7'b0001000));
        waitSel(4'b1011, 20);
`ifdef SEG7_LZB_EN
        lzbExp = 7'b1111111;
`else
        lzbExp = 7'b1000000;
`endif
        check("lz_digit2", 16'(oSEG), 16'(lzbExp));
        waitSel(4'b0111, 20);
        check("lz_digit3", 16'(oSEG), 16'(lzbExp));

        // Two loads in one frame: last wins, one ack
        waitSel(4'b1110, 20);
        ackSnap = ackTotal;
        load(16'hAAAA);
        load(16'h5555);
        repeat (40) @(negedge iCLK);
        check("single_ack", 16'(ackTotal - ackSnap), 16'd1);
        waitSel(4'b1110, 20);
        check("last_wins", 16'(oSEG), 16'(7'b0010010));

        // Load on the boundary cycle while data is pending
        load(16'h1111);
        waitSel(4'b0111, 20);
        repeat (3) @(negedge iCLK);
        load(16'h2222);
        check("boundary_ack", 16'(oACK), 16'h1);
        check("boundary_pend", 16'(oPEND), 16'h1);
        check("boundary_shows_old", 16'(oSEG), 16'(7'b1111001));
        waitAck(40);
        check("second_commit", 16'(oSEG), 16'(7'b0100100));
        check("pend_clear", 16'(oPEND), 16'h0);

        // Live blanking mask
        @(negedge iCLK); iBLANK_MASK = 4'b0100;
        waitSel(4'b1101, 20);
        waitSel(4'b1011, 20);
        check("mask_dark", 16'(oSEG), 16'h7F);
        @(negedge iCLK); iBLANK_MASK = 4'b0000;
        waitSel(4'b1101, 20);
        waitSel(4'b1011, 20);
        check("mask_restore", 16'(oSEG), 16'(7'b0100100));

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge iCLK);
            iLOAD = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       iDATA = 16'($urandom) & 16'h00FF;
                1:       iDATA = 16'($urandom) & 16'h000F;
                default: iDATA = 16'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) iBLANK_MASK = 4'($urandom);
        end
        @(negedge iCLK); iLOAD = 1'b0; iBLANK_MASK = '0;

        // Reset mid-frame with data pending
        waitSel(4'b1110, 20);
        load(16'h9999);
        @(negedge iCLK);
        check("pend_before_reset", 16'(oPEND), 16'h1);
        ackSnap = ackTotal;
        iRST_N = 1'b0;
        #1;
        check("rst_seg", 16'(oSEG), 16'h7F);
        check("rst_sel", 16'(oDIG_SEL), 16'hF);
        check("rst_pend", 16'(oPEND), 16'h0);
        check("rst_ack", 16'(oACK), 16'h0);
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (3) @(posedge iCLK);
        #1 check("post_rst_dark", 16'(oDIG_SEL), 16'hF);
        @(posedge iCLK);
        #1 check("post_rst_digit1", 16'(oDIG_SEL), 16'(4'b1101));
`ifdef SEG7_LZB_EN
        check("post_rst_seg", 16'(oSEG), 16'h7F);
`else
        check("post_rst_seg", 16'(oSEG), 16'(7'b1000000));
`endif
        repeat (20) @(negedge iCLK);
        check("no_ack_after_rst", 16'(ackTotal - ackSnap), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
